// File: rtl/skid_buffer.sv
// Two-entry skid buffer between an upstream producer and a downstream register
// slice. data_in_ready and data_out_valid come straight from flops, so neither
// ready nor valid has a combinational path through the block.
// Optional feature: define SKID_BUFFER_STALL_COUNT_EN to enable the saturating
// downstream stall counter on stall_count (otherwise it is tied to zero).
module skid_buffer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [15:0]           stall_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [DATA_WIDTH-1:0] RST_DATA = DATA_WIDTH'(RESET_VALUE);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_fire, out_fire;

  // Next-state and datapath: flush wins, then the occupancy transitions.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_fire  = data_in_valid & in_ready_q;
    out_fire = out_valid_q & data_out_ready;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = RST_DATA;
      skid_d  = RST_DATA;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            main_d  = data_in;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_d = data_in;
          end else if (in_fire) begin
            skid_d  = data_in;
            state_d = S_FULL;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = S_ONE;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    // Handshake flops are precomputed from the next occupancy.
    in_ready_d  = (state_d != S_FULL);
    out_valid_d = (state_d != S_EMPTY);
  end

  // State, data and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_q      <= RST_DATA;
      skid_q      <= RST_DATA;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_in_ready  = in_ready_q;
  assign data_out_valid = out_valid_q;
  assign data_out       = main_q;

`ifdef SKID_BUFFER_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Saturating count of cycles where valid output is held off by downstream.
  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (out_valid_q && !data_out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Directed and scoreboard checks for skid_buffer (DATA_WIDTH = 8).
module tb_skid_buffer;

  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] RV = 8'h3C;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic [15:0]   stall_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  skid_buffer #(.DATA_WIDTH(DW), .RESET_VALUE(32'(RV))) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus (called at a negedge), return at the next negedge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
    data_in_valid  = v;
    data_in        = d;
    data_out_ready = ordy;
    flush          = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; data_in = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (data_out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", data_out_valid); else pass_cnt++;
    total_cnt++; if (data_out !== RV) $display("FAIL reset_data: got %h expected %h", data_out, RV); else pass_cnt++;
    total_cnt++; if (data_in_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", data_in_ready); else pass_cnt++;
    total_cnt++; if (stall_count !== 16'h0) $display("FAIL reset_stall: got %h expected 0000", stall_count); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++; if (data_in_ready !== 1'b0) $display("FAIL release_ready_early: got %b expected 0", data_in_ready); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (data_in_ready !== 1'b1) $display("FAIL release_ready: got %b expected 1", data_in_ready); else pass_cnt++;
    total_cnt++; if (data_out_valid !== 1'b0) $display("FAIL release_valid: got %b expected 0", data_out_valid); else pass_cnt++;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, DW'(i), 1'b1, 1'b0);
      total_cnt++;
      if (data_out_valid !== 1'b1 || data_out !== DW'(i) || data_in_ready !== 1'b1)
        $display("FAIL stream_%0d: got v=%b d=%h r=%b expected v=1 d=%h r=1",
                 i, data_out_valid, data_out, data_in_ready, DW'(i));
      else pass_cnt++;
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (data_out_valid !== 1'b0) $display("FAIL stream_drain: got %b expected 0", data_out_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    total_cnt++;
    if (data_out !== 8'hA1 || data_out_valid !== 1'b1 || data_in_ready !== 1'b1)
      $display("FAIL bp_a1: got d=%h v=%b r=%b expected d=a1 v=1 r=1", data_out, data_out_valid, data_in_ready);
    else pass_cnt++;
    cyc(1'b1, 8'hA2, 1'b0, 1'b0);
    total_cnt++;
    if (data_out !== 8'hA1 || data_in_ready !== 1'b0)
      $display("FAIL bp_full: got d=%h r=%b expected d=a1 r=0", data_out, data_in_ready);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 8'hA3, 1'b0, 1'b0);
      total_cnt++;
      if (data_out !== 8'hA1 || data_out_valid !== 1'b1 || data_in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: got d=%h v=%b r=%b expected d=a1 v=1 r=0", i, data_out, data_out_valid, data_in_ready);
      else pass_cnt++;
    end
    cyc(1'b1, 8'hA3, 1'b1, 1'b0);
    total_cnt++;
    if (data_out !== 8'hA2 || data_out_valid !== 1'b1 || data_in_ready !== 1'b1)
      $display("FAIL bp_rel_a2: got d=%h v=%b r=%b expected d=a2 v=1 r=1", data_out, data_out_valid, data_in_ready);
    else pass_cnt++;
    cyc(1'b1, 8'hA3, 1'b1, 1'b0);
    total_cnt++;
    if (data_out !== 8'hA3 || data_out_valid !== 1'b1)
      $display("FAIL bp_rel_a3: got d=%h v=%b expected d=a3 v=1", data_out, data_out_valid);
    else pass_cnt++;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    total_cnt++; if (data_out_valid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", data_out_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b1);
    total_cnt++;
    if (data_out_valid !== 1'b0 || data_in_ready !== 1'b1 || data_out !== RV || stall_count !== 16'h0)
      $display("FAIL flush_full: got v=%b r=%b d=%h s=%h expected v=0 r=1 d=%h s=0000",
               data_out_valid, data_in_ready, data_out, stall_count, RV);
    else pass_cnt++;
    // flush in ONE with a same-cycle accepted input drops that input
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'hFF, 1'b1, 1'b0);
      total_cnt++;
      if (data_out_valid !== 1'b0 || data_out !== RV)
        $display("FAIL flush_quiet_%0d: got v=%b d=%h expected v=0 d=%h", i, data_out_valid, data_out, RV);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midtransfer();
    cyc(1'b1, 8'hD1, 1'b0, 1'b0);
    cyc(1'b1, 8'hD2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (data_out_valid !== 1'b0 || data_in_ready !== 1'b0 || data_out !== RV)
      $display("FAIL async_reset: got v=%b r=%b d=%h expected v=0 r=0 d=%h",
               data_out_valid, data_in_ready, data_out, RV);
    else pass_cnt++;
    data_in_valid = 1'b0; data_out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      total_cnt++;
      if (data_out_valid !== 1'b0 || data_in_ready !== 1'b1)
        $display("FAIL reset_discard_%0d: got v=%b r=%b expected v=0 r=1", i, data_out_valid, data_in_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall_count();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b1, 8'hE1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef SKID_BUFFER_STALL_COUNT_EN
    total_cnt++; if (stall_count !== 16'd5) $display("FAIL stall_5: got %h expected 0005", stall_count); else pass_cnt++;
    repeat (70000) @(negedge clk);
    total_cnt++; if (stall_count !== 16'hFFFF) $display("FAIL stall_sat: got %h expected ffff", stall_count); else pass_cnt++;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    total_cnt++; if (stall_count !== 16'h0) $display("FAIL stall_flush: got %h expected 0000", stall_count); else pass_cnt++;
`else
    total_cnt++; if (stall_count !== 16'h0) $display("FAIL stall_off: got %h expected 0000", stall_count); else pass_cnt++;
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
`endif
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    logic v, ordy, in_fire, out_fire;
    logic [DW-1:0] d;
    int errs;
    errs = 0;
    for (int c = 0; c < 10000; c++) begin
      total_cnt++;
      if (data_out_valid !== (q.size() != 0) || data_in_ready !== (q.size() < 2) ||
          (q.size() != 0 && data_out !== q[0])
`ifndef SKID_BUFFER_STALL_COUNT_EN
          || stall_count !== 16'h0
`endif
          ) begin
        if (errs < 10)
          $display("FAIL random_c%0d: got v=%b r=%b d=%h expected v=%b r=%b d=%h",
                   c, data_out_valid, data_in_ready, data_out, (q.size() != 0), (q.size() < 2),
                   (q.size() != 0) ? q[0] : data_out);
        errs++;
      end else pass_cnt++;
      v    = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      d    = DW'($urandom);
      in_fire  = v & (q.size() < 2);
      out_fire = ordy & (q.size() != 0);
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(d);
      cyc(v, d, ordy, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_reset_midtransfer();
    test_stall_count();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
